uart_reg_arb: RTL and testbench

Round-robin arbiter and access sequencer that shares the single UART register-file port (reg_addr/reg_wdata/reg_wstrb/reg_wen/reg_ren/reg_rdata/reg_error) between NREQ requesters, e.g. the AXI-lite slave and the RX DMA engine. It serialises accesses and drives reg_wen or reg_ren for exactly one cycle per granted access, because RX_DATA reads are destructive. It returns read data and error through a registered per-requester response handshake.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_reg_arb.sv | 131 +++++++++++++
 tb/tb_uart_reg_arb.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-port arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    localparam int DEFAULT_NUM_REGS = 8;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_BAUD      = 4'd2;
    localparam logic [3:0] ADDR_RX_DATA   = 4'd3;
    localparam logic [3:0] ADDR_TX_DATA   = 4'd4;
    localparam logic [3:0] ADDR_INT_EN    = 4'd5;
    localparam logic [3:0] ADDR_INT_STAT  = 4'd6;
    localparam logic [3:0] ADDR_FIFO_CTRL = 4'd7;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module uart_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    logic [PW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        // Walk from the farthest offset inward so the candidate nearest ptr is the last writer.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_reg_arb.sv
// Shares the single UART register-file port between NREQ requesters, one
// single-cycle strobe per granted access, with a registered per-requester response.
//
// state | meaning
// IDLE  | waiting for a request; req_ready follows the arbiter grant
// ISSUE | one-cycle reg_wen/reg_ren strobe; response captured at the closing edge
// RESP  | rsp_valid held for the owner until its rsp_ready
module uart_reg_arb
    import uart_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_REGS       = DEFAULT_NUM_REGS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0]                     req_write,
    input  logic [NREQ*REG_ADDR_WIDTH-1:0]      req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]          req_wdata,
    input  logic [NREQ*(DATA_WIDTH/8)-1:0]      req_wstrb,
    output logic [NREQ-1:0]                     rsp_valid,
    input  logic [NREQ-1:0]                     rsp_ready,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_error,
    output logic [REG_ADDR_WIDTH-1:0]           reg_addr,
    output logic [DATA_WIDTH-1:0]               reg_wdata,
    output logic [DATA_WIDTH/8-1:0]             reg_wstrb,
    output logic                                reg_wen,
    output logic                                reg_ren,
    input  logic [DATA_WIDTH-1:0]               reg_rdata,
    input  logic                                reg_error
);

    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              SW       = DATA_WIDTH / 8;
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

    arb_state_t                 state;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              owner;
    logic [PW-1:0]              grant_idx;
    logic [NREQ-1:0]            grant;
    logic                       any;
    logic                       cmd_write;

    logic                       sel_write;
    logic [REG_ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]      sel_wdata;
    logic [SW-1:0]              sel_wstrb;

    uart_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb[i*SW +: SW];
            end
        end
    end

    assign req_ready = (state == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cmd_write <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
            reg_wen   <= 1'b0;
            reg_ren   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        owner     <= grant_idx;
                        cmd_write <= sel_write;
                        reg_addr  <= sel_addr;
                        reg_wdata <= sel_wdata;
                        reg_wstrb <= sel_wstrb;
                        reg_wen   <= sel_write;
                        reg_ren   <= !sel_write;
                        ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    reg_wen   <= 1'b0;
                    reg_ren   <= 1'b0;
                    // Out-of-range writes still strobe; only the error flag reports them.
                    rsp_rdata <= cmd_write ? '0 : reg_rdata;
                    rsp_error <= cmd_write ? (32'(reg_addr) >= $unsigned(NUM_REGS)) : reg_error;
                    rsp_valid <= NREQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_arb.sv
// Scoreboard bench for uart_reg_arb with a small register-file model including a destructive RX_DATA pop.
module tb_uart_reg_arb;
    import uart_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int SW   = DW / 8;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_error;
    logic [AW-1:0]        reg_addr;
    logic [DW-1:0]        reg_wdata;
    logic [SW-1:0]        reg_wstrb;
    logic                 reg_wen;
    logic                 reg_ren;
    logic [DW-1:0]        reg_rdata;
    logic                 reg_error;

    logic [31:0] mem [16];
    logic [31:0] rx_val = 32'h0000_0100;
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    uart_reg_arb #(
        .NREQ           (NREQ),
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .NUM_REGS       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_wen   (reg_wen),
        .reg_ren   (reg_ren),
        .reg_rdata (reg_rdata),
        .reg_error (reg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read data/error, RX_DATA advances on every read strobe.
    assign reg_rdata = !reg_ren ? 32'h0 : ((reg_addr == ADDR_RX_DATA) ? rx_val : mem[reg_addr]);
    assign reg_error = reg_ren && (reg_addr >= 4'd8);

    always @(posedge clk)
        if (rst_n && reg_ren && reg_addr == ADDR_RX_DATA) rx_val <= rx_val + 32'd1;

    task automatic set_req(input int i, input bit w, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Drives a request at a negedge and returns one ns into the ISSUE cycle (or after a bounded wait).
    task automatic issue(input int i, input bit w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, output bit granted);
        granted = 1'b0;
        set_req(i, w, a, d, s);
        for (int c = 0; c < 16 && !granted; c++) begin
            #1;
            if (req_ready[i] === 1'b1) granted = 1'b1;
            @(negedge clk);
        end
        clr_req(i);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (rsp_valid !== '0) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_error, reg_wen, reg_ren} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0", {req_ready, rsp_valid, rsp_error, reg_wen, reg_ren});
        end
        vectors++;
        if (rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
        end
        vectors++;
        if ({reg_addr, reg_wdata, reg_wstrb} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_regbus: got %h expected 0", {reg_addr, reg_wdata, reg_wstrb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, reg_wen, reg_ren} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 0", {req_ready, rsp_valid, reg_wen, reg_ren});
        end
    endtask

    task automatic test_single_read;
        exp_t e;
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, 1'b0, ADDR_STATUS, 32'h0, 4'h0);
        sb.push_back('{0, 32'h0000_0005, 1'b0});
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 01", req_ready);
        end
        @(negedge clk);
        clr_req(0);
        #1;
        vectors++;
        if ({reg_ren, reg_wen, reg_addr, rsp_valid} !== {1'b1, 1'b0, 4'd1, 2'b00}) begin
            miscompares++;
            $display("FAIL single_strobe: got ren=%b wen=%b addr=%h rsp_valid=%b expected 1 0 1 00",
                     reg_ren, reg_wen, reg_addr, rsp_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (reg_ren !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ren_once: got %b expected 0", reg_ren);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL single_sb: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({rsp_valid, rsp_rdata, rsp_error} !== {2'(1 << e.owner), e.rdata, e.err}) begin
                miscompares++;
                $display("FAIL single_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                         rsp_valid, rsp_rdata, rsp_error, 2'(1 << e.owner), e.rdata, e.err);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_rsp_drop: got %b expected 00", rsp_valid);
        end
    endtask

    task automatic test_fairness;
        exp_t        e;
        int          grants;
        int          pulses;
        int          gcyc [4];
        int          idx;
        logic [31:0] exp_rx;
        do_reset();
        rsp_ready = 2'b11;
        grants    = 0;
        pulses    = 0;
        exp_rx    = rx_val;
        set_req(0, 1'b0, ADDR_RX_DATA, 32'h0, 4'h0);
        set_req(1, 1'b0, ADDR_RX_DATA, 32'h0, 4'h0);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (reg_ren === 1'b1) pulses++;
            if (req_ready !== 2'b00) begin
                idx = (req_ready === 2'b10) ? 1 : 0;
                vectors++;
                if (req_ready !== 2'(1 << (grants % 2))) begin
                    miscompares++;
                    $display("FAIL fair_order: grant %0d got %b expected %b", grants, req_ready, 2'(1 << (grants % 2)));
                end
                if (grants < 4) gcyc[grants] = c;
                grants++;
                sb.push_back('{idx, exp_rx, 1'b0});
                exp_rx = exp_rx + 32'd1;
            end
            if (rsp_valid !== 2'b00) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL fair_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_valid, rsp_rdata, rsp_error} !== {2'(1 << e.owner), e.rdata, e.err}) begin
                        miscompares++;
                        $display("FAIL fair_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                                 rsp_valid, rsp_rdata, rsp_error, 2'(1 << e.owner), e.rdata, e.err);
                    end
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        vectors++;
        if (grants != 4 || pulses != 4) begin
            miscompares++;
            $display("FAIL fair_count: got grants=%0d ren_pulses=%0d expected 4 4", grants, pulses);
        end else begin
            for (int k = 1; k < 4; k++) begin
                vectors++;
                if (gcyc[k] - gcyc[k-1] != 3) begin
                    miscompares++;
                    $display("FAIL fair_spacing: grant %0d spacing got %0d expected 3", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_write;
        exp_t e;
        bit   g;
        bit   ok;
        do_reset();
        rsp_ready = 2'b11;
        sb.push_back('{1, 32'h0, 1'b0});
        issue(1, 1'b1, ADDR_TX_DATA, 32'h0000_0010, 4'h1, g);
        vectors++;
        if ({g, reg_wen, reg_ren, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, 1'b1, 1'b0, 4'd4, 32'h10, 4'h1}) begin
            miscompares++;
            $display("FAIL write_strobe: got g=%b wen=%b ren=%b addr=%h wdata=%h wstrb=%h expected 1 1 0 4 10 1",
                     g, reg_wen, reg_ren, reg_addr, reg_wdata, reg_wstrb);
        end
        wait_rsp(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL write_rsp_timeout: got no rsp_valid expected 10");
        end else if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL write_sb: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({rsp_valid, rsp_rdata, rsp_error, reg_wen} !== {2'(1 << e.owner), e.rdata, e.err, 1'b0}) begin
                miscompares++;
                $display("FAIL write_rsp: got v=%b d=%h e=%b wen=%b expected v=%b d=%h e=%b wen=0",
                         rsp_valid, rsp_rdata, rsp_error, reg_wen, 2'(1 << e.owner), e.rdata, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_invalid;
        exp_t e;
        bit   g;
        bit   ok;
        do_reset();
        rsp_ready = 2'b11;
        for (int pass = 0; pass < 2; pass++) begin
            sb.push_back('{0, (pass == 0) ? 32'h0 : mem[9], 1'b1});
            issue(0, pass == 0, 4'd9, 32'h0000_1234, 4'hF, g);
            vectors++;
            if ({g, reg_wen, reg_ren, reg_addr} !== {1'b1, pass == 0, pass != 0, 4'd9}) begin
                miscompares++;
                $display("FAIL invalid_strobe%0d: got g=%b wen=%b ren=%b addr=%h expected 1 %b %b 9",
                         pass, g, reg_wen, reg_ren, reg_addr, pass == 0, pass != 0);
            end
            wait_rsp(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL invalid_timeout%0d: got no rsp_valid expected 01", pass);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL invalid_sb%0d: response with empty scoreboard", pass);
            end else begin
                e = sb.pop_front();
                if ({rsp_valid, rsp_rdata, rsp_error} !== {2'(1 << e.owner), e.rdata, e.err}) begin
                    miscompares++;
                    $display("FAIL invalid_rsp%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                             pass, rsp_valid, rsp_rdata, rsp_error, 2'(1 << e.owner), e.rdata, e.err);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        bit   g;
        bit   ok;
        do_reset();
        rsp_ready = 2'b10;
        sb.push_back('{0, mem[2], 1'b0});
        issue(0, 1'b0, ADDR_BAUD, 32'h0, 4'h0, g);
        set_req(1, 1'b0, ADDR_INT_EN, 32'h0, 4'h0);
        sb.push_back('{1, mem[5], 1'b0});
        vectors++;
        if ({g, reg_ren} !== 2'b11) begin
            miscompares++;
            $display("FAIL stall_issue: got g=%b ren=%b expected 1 1", g, reg_ren);
        end
        wait_rsp(ok);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({rsp_valid, rsp_rdata, rsp_error, req_ready, reg_ren, reg_wen} !==
                {2'b01, mem[2], 1'b0, 2'b00, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b d=%h e=%b rdy=%b ren=%b wen=%b expected 01 %h 0 00 0 0",
                         k, rsp_valid, rsp_rdata, rsp_error, req_ready, reg_ren, reg_wen, mem[2]);
            end
            @(negedge clk);
            #1;
        end
        rsp_ready = 2'b11;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_sb0: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({rsp_valid, rsp_rdata, rsp_error} !== {2'(1 << e.owner), e.rdata, e.err}) begin
                miscompares++;
                $display("FAIL stall_rsp0: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                         rsp_valid, rsp_rdata, rsp_error, 2'(1 << e.owner), e.rdata, e.err);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_next_grant: got %b expected 10", req_ready);
        end
        @(negedge clk);
        clr_req(1);
        #1;
        vectors++;
        if ({reg_ren, reg_addr} !== {1'b1, ADDR_INT_EN}) begin
            miscompares++;
            $display("FAIL stall_strobe1: got ren=%b addr=%h expected 1 5", reg_ren, reg_addr);
        end
        wait_rsp(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_timeout1: got no rsp_valid expected 10");
        end else if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_sb1: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({rsp_valid, rsp_rdata, rsp_error} !== {2'(1 << e.owner), e.rdata, e.err}) begin
                miscompares++;
                $display("FAIL stall_rsp1: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                         rsp_valid, rsp_rdata, rsp_error, 2'(1 << e.owner), e.rdata, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit g;
        do_reset();
        rsp_ready = 2'b11;
        issue(0, 1'b0, ADDR_RX_DATA, 32'h0, 4'h0, g);
        vectors++;
        if ({g, reg_ren, reg_addr} !== {1'b1, 1'b1, ADDR_RX_DATA}) begin
            miscompares++;
            $display("FAIL rstmid_issue: got g=%b ren=%b addr=%h expected 1 1 3", g, reg_ren, reg_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, reg_wen, reg_ren, reg_addr, reg_wdata, reg_wstrb} !== 79'h0) begin
            miscompares++;
            $display("FAIL rstmid_abort: got rdy=%b v=%b wen=%b ren=%b addr=%h expected all 0",
                     req_ready, rsp_valid, reg_wen, reg_ren, reg_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if ({reg_ren, reg_wen, rsp_valid} !== 4'b0) begin
                miscompares++;
                $display("FAIL rstmid_quiet%0d: got ren=%b wen=%b v=%b expected 0 0 00", k, reg_ren, reg_wen, rsp_valid);
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, ADDR_CTRL, 32'h0, 4'h0);
        set_req(1, 1'b0, ADDR_CTRL, 32'h0, 4'h0);
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_ptr: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        mem[1] = 32'h0000_0005;
        mem[2] = 32'h0000_A5A5;
        mem[9] = 32'hBAD0_0009;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write();
        test_invalid();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
